// File: rtl/periph_event_bridge.sv
// periph_event_bridge: debounced button events -> $r20 (acked through $r16), frame count -> $r22.
// Build option: define PERIPH_EVENT_RELEASE_EN to also report button release edges.
module periph_event_bridge #(
  parameter int NUM_BUTTONS     = 4,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                   clock,
  input  logic                   ctrl_reset_n,
  input  logic [NUM_BUTTONS-1:0] buttons_raw,
  input  logic                   screen_frame_done,
  input  logic [31:0]            r16,
  output logic [31:0]            r20,
  output logic                   button_signal_reg,
  output logic [31:0]            r22,
  output logic                   screen_signal_reg,
  output logic [1:0]             o_fsm_state
);
  localparam int CW  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int AW1 = AW + 1;
  localparam logic [CW-1:0] DB_LAST  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [AW:0]   FULL_CNT = AW1'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_PRESENT = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_CLEAR   = 2'd3;

`ifdef PERIPH_EVENT_RELEASE_EN
  localparam logic REL_EN = 1'b1;
`else
  localparam logic REL_EN = 1'b0;
`endif

  logic [NUM_BUTTONS-1:0] r_sync1, r_sync2, r_deb, r_pend, r_pend_press;
  logic [NUM_BUTTONS-1:0] w_flip, w_grant;
  logic [CW-1:0]          r_cnt [NUM_BUTTONS];
  logic                   w_any, w_grant_press;
  logic [2:0]             w_grant_idx;
  logic [3:0]             r_fifo [FIFO_DEPTH];
  logic [AW-1:0]          r_wr_ptr, r_rd_ptr;
  logic [AW:0]            r_count;
  logic                   w_full, w_pop, w_push, w_drop;
  logic [1:0]             r_state;
  logic [7:0]             r_seq;
  logic [3:0]             r_evt;
  logic                   r_ovf;
  logic [31:0]            r_r20, r_r22;
  logic                   r_btn_sig, r_scr_sig;
  logic                   w_unused_r16;

  assign w_unused_r16 = ^r16[31:8];

  always_comb begin
    w_flip = '0;
    for (int i = 0; i < NUM_BUTTONS; i++)
      w_flip[i] = (r_sync2[i] != r_deb[i]) && (r_cnt[i] == DB_LAST);
  end

  // Lowest-index pending button wins the single enqueue slot each cycle.
  always_comb begin
    w_grant       = '0;
    w_any         = 1'b0;
    w_grant_idx   = 3'd0;
    w_grant_press = 1'b0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (r_pend[i] && !w_any) begin
        w_any         = 1'b1;
        w_grant[i]    = 1'b1;
        w_grant_idx   = 3'(i);
        w_grant_press = r_pend_press[i];
      end
    end
  end

  assign w_full = (r_count == FULL_CNT);
  assign w_pop  = (r_state == S_IDLE) && (r_count != '0);
  assign w_push = w_any && (!w_full || w_pop);
  assign w_drop = w_any && !w_push;

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      r_sync1      <= '0;
      r_sync2      <= '0;
      r_deb        <= '0;
      r_pend       <= '0;
      r_pend_press <= '0;
      for (int i = 0; i < NUM_BUTTONS; i++) r_cnt[i] <= '0;
    end else begin
      r_sync1 <= buttons_raw;
      r_sync2 <= r_sync1;
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        if (r_sync2[i] == r_deb[i]) begin
          r_cnt[i] <= '0;
        end else if (w_flip[i]) begin
          r_cnt[i] <= '0;
          r_deb[i] <= r_sync2[i];
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
        if (w_flip[i] && (r_sync2[i] || REL_EN)) begin
          r_pend[i]       <= 1'b1;
          r_pend_press[i] <= r_sync2[i];
        end else if (w_grant[i]) begin
          r_pend[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_fifo[r_wr_ptr] <= {w_grant_press, w_grant_idx};
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + AW1'(1);
      else if (!w_push && w_pop) r_count <= r_count - AW1'(1);
      // A drop in the same cycle as PRESENT must survive into the next word.
      if (w_drop)                     r_ovf <= 1'b1;
      else if (r_state == S_PRESENT)  r_ovf <= 1'b0;
    end
  end

  // Handshake: the word stays on r20 until r16[7:0] equals its seq; seq never takes 0.
  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      r_state   <= S_IDLE;
      r_seq     <= 8'd1;
      r_evt     <= '0;
      r_r20     <= '0;
      r_btn_sig <= 1'b0;
    end else begin
      r_btn_sig <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_evt   <= r_fifo[r_rd_ptr];
            r_state <= S_PRESENT;
          end
        end
        S_PRESENT: begin
          r_r20     <= {1'b1, r_ovf, 6'd0, r_seq, 8'd0, r_evt[3], 4'd0, r_evt[2:0]};
          r_btn_sig <= 1'b1;
          r_state   <= S_WAIT;
        end
        S_WAIT: begin
          if (r16[7:0] == r_seq) r_state <= S_CLEAR;
        end
        default: begin
          r_r20     <= '0;
          r_btn_sig <= 1'b1;
          r_seq     <= (r_seq == 8'd255) ? 8'd1 : r_seq + 8'd1;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge ctrl_reset_n) begin
    if (!ctrl_reset_n) begin
      r_r22     <= '0;
      r_scr_sig <= 1'b0;
    end else begin
      r_scr_sig <= screen_frame_done;
      if (screen_frame_done) r_r22 <= r_r22 + 32'd1;
    end
  end

  assign r20               = r_r20;
  assign button_signal_reg = r_btn_sig;
  assign r22               = r_r22;
  assign screen_signal_reg = r_scr_sig;
  assign o_fsm_state       = r_state;
endmodule

// File: doc/periph_event_bridge.md
Name: periph_event_bridge

Overview:
- Peripheral-side writer for the register file's hardware-fed registers.
- Debounces the board buttons and queues press/release events. Presents each event to $r20 via the r20 bus plus a button_signal_reg write strobe, then waits for the processor to acknowledge through $r16.
- Also counts display frame-done pulses and publishes the count to $r22 via the r22 bus plus a screen_signal_reg write strobe.
- Sits between the board I/O / VGA controller and the processor regfile.

Parameters:
NUM_BUTTONS, 4, number of button inputs (1..8)
DEBOUNCE_CYCLES, 250000, consecutive stable cycles required to accept a level change (must be >= NUM_BUTTONS+2)
FIFO_DEPTH, 4, event queue entries (power of 2, >= 2)

Ports:
clock  in  1  system clock
ctrl_reset_n  in  1  asynchronous active-low reset
buttons_raw  in  NUM_BUTTONS  asynchronous button levels, 1 = pressed
screen_frame_done  in  1  single-cycle pulse, synchronous to clock, once per frame
r16  in  32  current $r16 value; processor ack register
r20  out  32  event word to regfile reg20 D input
button_signal_reg  out  1  one-cycle write strobe for reg20
r22  out  32  frame count to regfile reg22 D input
screen_signal_reg  out  1  one-cycle write strobe for reg22

Behaviour:
- Interface: one clock, `clock`. Reset `ctrl_reset_n` is asynchronous and active-low.
- Reset values:
  - All outputs 0.
  - FIFO empty; pending flags, overflow flag and frame counter cleared.
  - Sequence number = 1; FSM in IDLE.
  - Debounced state = 0.
  - Reset mid-operation abandons any presented or queued event; no clear strobe is issued.
- Button path, per button:
  - 2-flop synchronizer.
  - Counter counts cycles where the synchronized level differs from the debounced state; resets on any agreement.
  - When the counter reaches DEBOUNCE_CYCLES, the debounced state flips and the button's pending flag sets for the detected edge.
- Arbiter: each cycle, enqueues the lowest-index pending event if the FIFO is not full, then clears that flag.
  - If the FIFO is full, the event is dropped, its flag clears, and the sticky overflow flag sets.
- Event word layout:
  - [31] valid = 1
  - [30] overflow
  - [29:24] = 0
  - [23:16] seq
  - [15:8] = 0
  - [7] 1 = press, 0 = release
  - [6:3] = 0
  - [2:0] button index
- Presentation FSM:
  - IDLE: FIFO non-empty -> pop, register word with the current seq, go to PRESENT.
  - PRESENT: drive the word on r20, button_signal_reg = 1 for exactly this cycle, clear the overflow flag (it was captured in the word), go to WAIT_ACK.
  - WAIT_ACK: r20 holds the word, strobe 0. When r16[7:0] == seq, go to CLEAR.
  - CLEAR: r20 = 0, button_signal_reg = 1 for one cycle. seq increments, wrapping 255 -> 1 (0 is never used, so $r16 reset value never acks). Go to IDLE.
- Latency: raw edge -> PRESENT strobe = DEBOUNCE_CYCLES + 5 cycles when the FSM is idle and the FIFO is empty.
  - 2 sync, DEBOUNCE_CYCLES debounce, 1 enqueue, 1 pop, 1 present.
- Simultaneous edges on several buttons: enqueued one per cycle in ascending index order.
- FIFO pop and arbiter push in the same cycle are both allowed when full; the push succeeds.
- Frame path: a cycle with screen_frame_done = 1 increments the 32-bit frame counter (wraps 0xFFFFFFFF -> 0).
  - Next cycle: r22 = new count and screen_signal_reg = 1 for one cycle; r22 holds until the next pulse.
  - Back-to-back pulses each produce their own strobe.
- Button and frame paths are independent; strobes may coincide.

Optional Feature:
- Macro PERIPH_EVENT_RELEASE_EN.
- Defined: both press and release edges generate events.
- Undefined: release edges update the debounced state only; no pending flag is set and no event is ever produced with bit7 = 0.

Test Plan:
1. DEBOUNCE_CYCLES=4; hold buttons_raw[2] high 20 cycles from idle -> button_signal_reg at cycle 9 with r20=0x80010082; r20 holds until ack.
2. After test 1, set r16=0x00000001 -> CLEAR one cycle later: r20=0, one strobe; next event carries seq 2 (word 0x80020002 on release with PERIPH_EVENT_RELEASE_EN).
3. Pulse buttons_raw[1] high for 3 cycles (DEBOUNCE_CYCLES=4) -> no strobe, FIFO stays empty.
4. FIFO_DEPTH=2; raise buttons 0..3 in the same cycle, no ack:
   - First word 0x80010080.
   - Ack each in turn -> next words 0xC0020081, 0x80030082.
   - Button 3 dropped; FSM then idles.
5. Three screen_frame_done pulses at cycles 10, 11, 20 -> screen_signal_reg at 11, 12, 21 with r22 = 1, 2, 3.
6. Assert ctrl_reset_n low while in WAIT_ACK -> outputs 0 immediately. After release, a new press presents with seq 1.
